hit_resolver: RTL and testbench
===============================

Name: hit_resolver

Overview:
- Frame-rate sequencer for the combinational hit detector output (per-player 2-bit "has been hit" flags: 00 none, 01 basic, 10 directional).
- Converts level flags into exactly one damage event per attack contact, applies damage to each player's health, and runs hitstun timers with invulnerability.
- Re-arms each player only after the flag clears, and declares the round winner.
- Sits between the hit detector and the player state machines / HUD renderer.

Parameters:
- HEALTH_W, 4, health register width.
- HEALTH_INIT, 10, health loaded on reset and on round_start.
- DMG_BASIC, 1, damage for a basic hit.
- DMG_DIR, 2, damage for a directional hit.
- STUN_W, 5, stun counter width.
- STUN_BASIC, 10, hitstun length in frames for a basic hit.
- STUN_DIR, 16, hitstun length in frames for a directional hit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame; all sampling and counting happens only on this pulse.
- round_start  in  1  synchronous pulse; restarts the round.
- p1_hit_flag  in  2  P1 hit flag from the hit detector.
- p2_hit_flag  in  2  P2 hit flag from the hit detector.
- p1_health  out  HEALTH_W  P1 remaining health.
- p2_health  out  HEALTH_W  P2 remaining health.
- p1_stun  out  1  P1 in hitstun; player FSM forces its hitstun state.
- p2_stun  out  1  P2 in hitstun.
- p1_hit_pulse  out  1  one-cycle pulse when a P1 hit is registered.
- p2_hit_pulse  out  1  one-cycle pulse when a P2 hit is registered.
- game_over  out  1  round finished.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

Behaviour:
- Reset values: health = HEALTH_INIT, stun = 0, hit pulses = 0, game_over = 0, winner = 00, both channels in ARMED.
- round_start has the same effect as reset, applied at the clock edge. It takes priority over a coincident frame_tick.
- Per-player channel FSM, with all transitions qualified by frame_tick:
  - ARMED, flag 01 or 10: health <= sat0(health - dmg); cnt <= STUN_x; hit_pulse = 1 for the next cycle; next state is KO if the new health is 0, otherwise STUN.
  - ARMED, flag 00 or 11: stay in ARMED. 11 is illegal and ignored.
  - STUN: flags ignored (invulnerable). If cnt == 1, cnt <= 0 and go to LOCKOUT; otherwise cnt <= cnt - 1.
  - LOCKOUT: go to ARMED only when the flag is sampled as 00. A flag held through the whole stun never causes a second hit.
  - KO: hold until round_start or rst.
- Latency: the flag is sampled on the tick cycle; health, stun, and hit_pulse change at that clock edge and are visible the following cycle.
- Stun duration: stun is high for exactly STUN_x frame ticks after the hit tick.
- Damage saturates at 0; health never wraps.
- Global:
  - game_over = 1 once either channel is in KO.
  - While game_over is set, ARMED channels ignore flags, so health is frozen.
  - winner = 01 if P2 is KO, 10 if P1 is KO, 11 if both reach KO on the same tick.
  - winner is latched and held until round_start.
- Simultaneous hits on one tick are applied to both players independently.
- Ticks while frame_tick = 0 change nothing except clearing hit_pulse.

Decomposition:
- Shared package contains:
  - hit flag encodings (HIT_NONE, HIT_BASIC, HIT_DIR);
  - winner encodings;
  - channel state encodings (ARMED, STUN, LOCKOUT, KO), placed alongside the existing player-state constants.
- One sub-module, hit_channel: a per-player FSM with a health register, stun counter, and pulse output. It is instantiated twice.
- The top level holds only game_over / winner logic and the freeze input to each channel.

Test Plan:
- Reset, then p2_hit_flag = 01 held for 30 ticks:
  - p2_health goes 10 to 9 once, with a single p2_hit_pulse;
  - p2_stun is high for 10 ticks;
  - the channel stays in LOCKOUT; no second hit.
- Flag 10 for 1 tick, then 00, then 10 again on tick 20: health goes 10, 8, 6; p1_stun is high for 16 ticks each time.
- Flag 01 arriving on tick 5 of the stun: ignored; health is unchanged.
- P2 health at 1, then flag 10: health reads 0 (not 15); game_over = 1; winner = 01; later flags are ignored.
- Both players at health 2, both flags 10 on the same tick: both reach 0; winner = 11.
- round_start coincident with a tick and a flag of 01: health = 10; no hit pulse; game_over = 0.

Source files
------------

// File: rtl/hit_resolver_pkg.sv
// Shared encodings for the hit resolver: detector flags, round winner codes
// and the per-player channel states.
package hit_resolver_pkg;

  localparam logic [1:0] HIT_NONE  = 2'b00;
  localparam logic [1:0] HIT_BASIC = 2'b01;
  localparam logic [1:0] HIT_DIR   = 2'b10;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_P1    = 2'b01;
  localparam logic [1:0] WIN_P2    = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  typedef enum logic [1:0] {
    CH_ARMED   = 2'b00,
    CH_STUN    = 2'b01,
    CH_LOCKOUT = 2'b10,
    CH_KO      = 2'b11
  } ch_state_e;

endpackage

// File: rtl/hit_resolver_channel.sv
// One player's damage channel: turns a level hit flag into a single hit per
// contact, tracks health, and runs hitstun plus re-arm lockout.
module hit_channel
  import hit_resolver_pkg::*;
#(
  parameter int HEALTH_W    = 4,
  parameter int HEALTH_INIT = 10,
  parameter int DMG_BASIC   = 1,
  parameter int DMG_DIR     = 2,
  parameter int STUN_W      = 5,
  parameter int STUN_BASIC  = 10,
  parameter int STUN_DIR    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_i,
  input  logic                restart_i,
  input  logic                freeze_i,
  input  logic [1:0]          flag_i,
  output logic [HEALTH_W-1:0] health_o,
  output logic                stun_o,
  output logic                hit_pulse_o,
  output logic                ko_o
);

  ch_state_e             state_q;
  logic [HEALTH_W-1:0]   health_q, health_d, dmg;
  logic [STUN_W-1:0]     cnt_q, stun_len;
  logic                  pulse_q;
  logic                  hit_valid;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    dmg      = HEALTH_W'(DMG_BASIC);
    stun_len = STUN_W'(STUN_BASIC);
    if (flag_i == HIT_DIR) begin
      dmg      = HEALTH_W'(DMG_DIR);
      stun_len = STUN_W'(STUN_DIR);
    end
    // Saturate at zero so a low-health player never wraps to full.
    health_d  = (health_q <= dmg) ? '0 : health_q - dmg;
    hit_valid = !freeze_i && (flag_i == HIT_BASIC || flag_i == HIT_DIR);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CH_ARMED;
      health_q <= HEALTH_W'(HEALTH_INIT);
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (restart_i) begin
        state_q  <= CH_ARMED;
        health_q <= HEALTH_W'(HEALTH_INIT);
        cnt_q    <= '0;
      end else if (tick_i) begin
        case (state_q)
          CH_ARMED: begin
            if (hit_valid) begin
              health_q <= health_d;
              cnt_q    <= stun_len;
              pulse_q  <= 1'b1;
              state_q  <= (health_d == '0) ? CH_KO : CH_STUN;
            end
          end
          CH_STUN: begin
            if (cnt_q == STUN_W'(1)) begin
              cnt_q   <= '0;
              state_q <= CH_LOCKOUT;
            end else begin
              cnt_q <= cnt_q - STUN_W'(1);
            end
          end
          // A flag held through stun must drop to none before re-arming.
          CH_LOCKOUT: if (flag_i == HIT_NONE) state_q <= CH_ARMED;
          CH_KO:      state_q <= CH_KO;
          default:    state_q <= CH_ARMED;
        endcase
      end
    end
  end

  assign health_o    = health_q;
  assign stun_o      = (state_q == CH_STUN);
  assign hit_pulse_o = pulse_q;
  assign ko_o        = (state_q == CH_KO);

endmodule

// File: rtl/hit_resolver.sv
// Frame-rate hit sequencer: two player damage channels plus round-over and
// winner resolution.
module hit_resolver
  import hit_resolver_pkg::*;
#(
  parameter int HEALTH_W    = 4,
  parameter int HEALTH_INIT = 10,
  parameter int DMG_BASIC   = 1,
  parameter int DMG_DIR     = 2,
  parameter int STUN_W      = 5,
  parameter int STUN_BASIC  = 10,
  parameter int STUN_DIR    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                round_start,
  input  logic [1:0]          p1_hit_flag,
  input  logic [1:0]          p2_hit_flag,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                p1_stun,
  output logic                p2_stun,
  output logic                p1_hit_pulse,
  output logic                p2_hit_pulse,
  output logic                game_over,
  output logic [1:0]          winner
);

  logic p1_ko, p2_ko;

  // KO is sticky until round_start, so decoding it gives a latched result;
  // once set, the freeze stops the survivor's health from moving.
  assign game_over = p1_ko | p2_ko;
  assign winner    = p1_ko ? (p2_ko ? WIN_DRAW : WIN_P2)
                           : (p2_ko ? WIN_P1 : WIN_NONE);

  hit_channel #(
    .HEALTH_W(HEALTH_W), .HEALTH_INIT(HEALTH_INIT), .DMG_BASIC(DMG_BASIC),
    .DMG_DIR(DMG_DIR), .STUN_W(STUN_W), .STUN_BASIC(STUN_BASIC), .STUN_DIR(STUN_DIR)
  ) u_p1 (
    .clk(clk), .rst(rst), .tick_i(frame_tick), .restart_i(round_start),
    .freeze_i(game_over), .flag_i(p1_hit_flag), .health_o(p1_health),
    .stun_o(p1_stun), .hit_pulse_o(p1_hit_pulse), .ko_o(p1_ko)
  );

  hit_channel #(
    .HEALTH_W(HEALTH_W), .HEALTH_INIT(HEALTH_INIT), .DMG_BASIC(DMG_BASIC),
    .DMG_DIR(DMG_DIR), .STUN_W(STUN_W), .STUN_BASIC(STUN_BASIC), .STUN_DIR(STUN_DIR)
  ) u_p2 (
    .clk(clk), .rst(rst), .tick_i(frame_tick), .restart_i(round_start),
    .freeze_i(game_over), .flag_i(p2_hit_flag), .health_o(p2_health),
    .stun_o(p2_stun), .hit_pulse_o(p2_hit_pulse), .ko_o(p2_ko)
  );

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: each scenario task drives ticks and
// compares outputs against hand-computed values.
module tb_hit_resolver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       round_start = 1'b0;
  logic [1:0] p1_hit_flag = 2'b00;
  logic [1:0] p2_hit_flag = 2'b00;
  logic [3:0] p1_health, p2_health;
  logic       p1_stun, p2_stun, p1_hit_pulse, p2_hit_pulse, game_over;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;

  hit_resolver dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .round_start(round_start),
    .p1_hit_flag(p1_hit_flag), .p2_hit_flag(p2_hit_flag),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_stun(p1_stun), .p2_stun(p2_stun),
    .p1_hit_pulse(p1_hit_pulse), .p2_hit_pulse(p2_hit_pulse),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // One frame tick with the given flags; returns at the following negedge,
  // where the results of that tick are visible.
  task automatic tick(input logic [1:0] f1, input logic [1:0] f2);
    @(negedge clk);
    p1_hit_flag = f1;
    p2_hit_flag = f2;
    frame_tick  = 1'b1;
    @(negedge clk);
    frame_tick  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    p1_hit_flag = 2'b00;
    p2_hit_flag = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drop both flags long enough for any stun and lockout to clear.
  task automatic recover();
    for (int i = 0; i < 20; i++) tick(2'b00, 2'b00);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (p1_health !== 4'd10 || p2_health !== 4'd10) begin
      errors++; $display("FAIL reset_health p1=%0d p2=%0d expected 10/10", p1_health, p2_health);
    end
    checks++;
    if ({p1_stun, p2_stun, p1_hit_pulse, p2_hit_pulse, game_over, winner} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags stun=%b%b pulse=%b%b go=%b win=%b expected all zero",
               p1_stun, p2_stun, p1_hit_pulse, p2_hit_pulse, game_over, winner);
    end
    // Flags without a tick must not register anything.
    p1_hit_flag = 2'b10;
    p2_hit_flag = 2'b01;
    repeat (4) @(negedge clk);
    checks++;
    if (p1_health !== 4'd10 || p2_health !== 4'd10 || p1_hit_pulse !== 1'b0) begin
      errors++; $display("FAIL no_tick p1=%0d p2=%0d pulse=%b expected 10/10/0",
                         p1_health, p2_health, p1_hit_pulse);
    end
    p1_hit_flag = 2'b00;
    p2_hit_flag = 2'b00;
  endtask

  task automatic test_held_flag();
    int pulses = 0;
    int stun_ticks = 0;
    apply_reset();
    tick(2'b00, 2'b01);
    checks++;
    if (p2_health !== 4'd9 || p2_hit_pulse !== 1'b1 || p2_stun !== 1'b1) begin
      errors++; $display("FAIL held_first_hit health=%0d pulse=%b stun=%b expected 9/1/1",
                         p2_health, p2_hit_pulse, p2_stun);
    end
    pulses += int'(p2_hit_pulse);
    stun_ticks += int'(p2_stun);
    @(negedge clk);
    checks++;
    if (p2_hit_pulse !== 1'b0) begin
      errors++; $display("FAIL pulse_width pulse=%b expected 0", p2_hit_pulse);
    end
    for (int i = 1; i < 30; i++) begin
      tick(2'b00, 2'b01);
      pulses += int'(p2_hit_pulse);
      stun_ticks += int'(p2_stun);
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL held_pulses count=%0d expected 1", pulses);
    end
    checks++;
    if (stun_ticks !== 10) begin
      errors++; $display("FAIL held_stun_len ticks=%0d expected 10", stun_ticks);
    end
    checks++;
    if (p2_health !== 4'd9 || p1_health !== 4'd10) begin
      errors++; $display("FAIL held_health p2=%0d p1=%0d expected 9/10", p2_health, p1_health);
    end
  endtask

  task automatic test_dir_rehit();
    int pulses = 0;
    int stun_a = 0;
    int stun_b = 0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      tick((i == 0 || i == 20) ? 2'b10 : 2'b00, 2'b00);
      if (i == 0) begin
        checks++;
        if (p1_health !== 4'd8) begin
          errors++; $display("FAIL dir_first health=%0d expected 8", p1_health);
        end
      end
      pulses += int'(p1_hit_pulse);
      if (i < 20) stun_a += int'(p1_stun);
      else        stun_b += int'(p1_stun);
    end
    checks++;
    if (p1_health !== 4'd6 || pulses !== 2) begin
      errors++; $display("FAIL dir_rehit health=%0d pulses=%0d expected 6/2", p1_health, pulses);
    end
    checks++;
    if (stun_a !== 16 || stun_b !== 16) begin
      errors++; $display("FAIL dir_stun_len first=%0d second=%0d expected 16/16", stun_a, stun_b);
    end
  endtask

  task automatic test_stun_invuln();
    apply_reset();
    tick(2'b01, 2'b00);
    for (int i = 1; i < 5; i++) tick(2'b00, 2'b00);
    tick(2'b01, 2'b00);
    checks++;
    if (p1_health !== 4'd9 || p1_hit_pulse !== 1'b0 || p1_stun !== 1'b1) begin
      errors++; $display("FAIL stun_invuln health=%0d pulse=%b stun=%b expected 9/0/1",
                         p1_health, p1_hit_pulse, p1_stun);
    end
  endtask

  task automatic test_ko();
    apply_reset();
    for (int i = 0; i < 4; i++) begin tick(2'b00, 2'b10); recover(); end
    tick(2'b00, 2'b01); recover();
    checks++;
    if (p2_health !== 4'd1 || game_over !== 1'b0) begin
      errors++; $display("FAIL ko_setup health=%0d go=%b expected 1/0", p2_health, game_over);
    end
    tick(2'b00, 2'b10);
    checks++;
    if (p2_health !== 4'd0 || p2_hit_pulse !== 1'b1) begin
      errors++; $display("FAIL ko_saturate health=%0d pulse=%b expected 0/1", p2_health, p2_hit_pulse);
    end
    checks++;
    if (game_over !== 1'b1 || winner !== 2'b01) begin
      errors++; $display("FAIL ko_winner go=%b winner=%b expected 1/01", game_over, winner);
    end
    tick(2'b01, 2'b10);
    tick(2'b00, 2'b00);
    tick(2'b10, 2'b01);
    checks++;
    if (p1_health !== 4'd10 || p2_health !== 4'd0 || p1_hit_pulse !== 1'b0 || winner !== 2'b01) begin
      errors++; $display("FAIL ko_frozen p1=%0d p2=%0d pulse=%b winner=%b expected 10/0/0/01",
                         p1_health, p2_health, p1_hit_pulse, winner);
    end
  endtask

  task automatic test_draw();
    apply_reset();
    for (int i = 0; i < 4; i++) begin tick(2'b10, 2'b10); recover(); end
    checks++;
    if (p1_health !== 4'd2 || p2_health !== 4'd2) begin
      errors++; $display("FAIL draw_setup p1=%0d p2=%0d expected 2/2", p1_health, p2_health);
    end
    tick(2'b10, 2'b10);
    checks++;
    if (p1_health !== 4'd0 || p2_health !== 4'd0 || game_over !== 1'b1 || winner !== 2'b11) begin
      errors++; $display("FAIL draw p1=%0d p2=%0d go=%b winner=%b expected 0/0/1/11",
                         p1_health, p2_health, game_over, winner);
    end
  endtask

  task automatic test_round_start();
    // Entered from the draw, so both channels are in KO.
    @(negedge clk);
    round_start = 1'b1;
    frame_tick  = 1'b1;
    p1_hit_flag = 2'b00;
    p2_hit_flag = 2'b01;
    @(negedge clk);
    round_start = 1'b0;
    frame_tick  = 1'b0;
    checks++;
    if (p1_health !== 4'd10 || p2_health !== 4'd10 || p2_hit_pulse !== 1'b0) begin
      errors++; $display("FAIL restart_health p1=%0d p2=%0d pulse=%b expected 10/10/0",
                         p1_health, p2_health, p2_hit_pulse);
    end
    checks++;
    if (game_over !== 1'b0 || winner !== 2'b00 || p2_stun !== 1'b0) begin
      errors++; $display("FAIL restart_state go=%b winner=%b stun=%b expected 0/00/0",
                         game_over, winner, p2_stun);
    end
    tick(2'b00, 2'b01);
    checks++;
    if (p2_health !== 4'd9 || p2_hit_pulse !== 1'b1) begin
      errors++; $display("FAIL restart_rearmed health=%0d pulse=%b expected 9/1", p2_health, p2_hit_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_held_flag();
    test_dir_rehit();
    test_stun_invuln();
    test_ko();
    test_draw();
    test_round_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
